proj_fm_kmer_reader: RTL and testbench

Read-side consumer of the FM RAM's window output: captures each multi-byte window word, buffers it in a small word FIFO, and serializes it into overlapping k-mers with a position tag for the downstream MinHash hasher. It sits between the FM RAM read port, which delivers one word per valid cycle with no backpressure, and the hash pipeline, which applies valid/ready backpressure. It also flags buffer boundaries and FIFO overflow.

---
 rtl/proj_pkg.sv | 21 ++
 rtl/proj_sync_fifo.sv | 62 ++++++
 rtl/proj_fm_kmer_reader.sv | 140 ++++++++++++++
 tb/tb_proj_fm_kmer_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared FM constants and types for the FM RAM read side.
// Reader FIFO depth and k-mer length live here so the hasher can agree on them.
package proj_pkg;

    localparam int FM_GENOME_BTYE        = 8;
    localparam int FM_ADDRESS_READ_COUNT = 8;
    localparam int FM_BUFFER_COUNT       = 2;
    localparam int FM_KMER_LEN           = 4;
    localparam int FM_READER_FIFO_DEPTH  = 4;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_EMIT = 1'b1
    } kmer_rd_state_t;

    // Counter width that stays at least one bit for degenerate ranges.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/proj_sync_fifo.sv
// Small synchronous word FIFO with show-ahead read of the head entry.
// A push into a full FIFO is only taken when a pop happens on the same edge.
module proj_sync_fifo
    import proj_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr_reg];

    // Storage carries no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/proj_fm_kmer_reader.sv
// Captures FM RAM window words into a FIFO and serializes each word into
// overlapping k-mers tagged with their byte offset inside the current buffer.
module proj_fm_kmer_reader
    import proj_pkg::*;
#(
    parameter int DATA_BITS            = FM_GENOME_BTYE,
    parameter int READ_ADDRESSES_COUNT = FM_ADDRESS_READ_COUNT,
    parameter int KMER_LEN             = FM_KMER_LEN,
    parameter int BLOCK_WORDS          = 64,
    parameter int FIFO_DEPTH           = FM_READER_FIFO_DEPTH,
    localparam int POS_BITS            = $clog2(BLOCK_WORDS * READ_ADDRESSES_COUNT)
) (
    input  logic                                    in_clk,
    input  logic                                    in_rst_n,
    input  logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0] in_rdata,
    input  logic                                    in_rvalid,
    input  logic                                    in_buf_start,
    input  logic                                    in_ready,
    output logic                                    out_valid,
    output logic [KMER_LEN*DATA_BITS-1:0]           out_kmer,
    output logic [POS_BITS-1:0]                     out_pos,
    output logic                                    out_buf_done,
    output logic                                    out_overflow
);

    localparam int W         = READ_ADDRESSES_COUNT;
    localparam int NK        = W - KMER_LEN + 1;
    localparam int JW        = clog2_min1(NK);
    localparam int WORD_BITS = W * DATA_BITS;
    localparam int KMER_BITS = KMER_LEN * DATA_BITS;

    logic [WORD_BITS:0]   fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    kmer_rd_state_t       state_reg;
    logic [WORD_BITS-1:0] hold_reg;
    logic [JW-1:0]        j_reg;
    logic [POS_BITS-1:0]  word_idx_reg;
    logic [POS_BITS-1:0]  word_idx_next;
    logic                 seen_word_reg;
    logic                 overflow_reg;
    logic                 last_kmer;
    logic [KMER_BITS-1:0] kmer_slice [NK];

    proj_sync_fifo #(
        .WIDTH (WORD_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk   (in_clk),
        .rst_n (in_rst_n),
        .push  (in_rvalid),
        .pop   (fifo_pop),
        .wdata ({in_buf_start, in_rdata}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign last_kmer = (j_reg == JW'(NK - 1));

    // Pop when idle, or on the final handshake of a word so the next one follows without a bubble.
    assign fifo_pop = ~fifo_empty &
                      ((state_reg == RD_IDLE) | (in_ready & last_kmer));

    always_comb begin
        word_idx_next = word_idx_reg;
        if (fifo_rdata[WORD_BITS]) begin
            word_idx_next = '0;
        end else if (seen_word_reg) begin
            word_idx_next = (word_idx_reg == POS_BITS'(BLOCK_WORDS - 1)) ?
                            '0 : word_idx_reg + POS_BITS'(1);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_reg     <= RD_IDLE;
            hold_reg      <= '0;
            j_reg         <= '0;
            word_idx_reg  <= '0;
            seen_word_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (in_rvalid & fifo_full & ~fifo_pop) begin
                overflow_reg <= 1'b1;
            end
            if (fifo_pop) begin
                hold_reg      <= fifo_rdata[WORD_BITS-1:0];
                word_idx_reg  <= word_idx_next;
                seen_word_reg <= 1'b1;
            end
            case (state_reg)
                RD_IDLE: begin
                    if (fifo_pop) begin
                        state_reg <= RD_EMIT;
                        j_reg     <= '0;
                    end
                end
                RD_EMIT: begin
                    if (in_ready) begin
                        if (!last_kmer) begin
                            j_reg <= j_reg + JW'(1);
                        end else begin
                            j_reg <= '0;
                            if (!fifo_pop) begin
                                state_reg <= RD_IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= RD_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_kmer_slice
            assign kmer_slice[gi] = hold_reg[gi*DATA_BITS +: KMER_BITS];
        end
    endgenerate

    always_comb begin
        out_kmer = '0;
        for (int i = 0; i < NK; i++) begin
            if (j_reg == JW'(i)) begin
                out_kmer = kmer_slice[i];
            end
        end
    end

    assign out_valid    = (state_reg == RD_EMIT);
    assign out_pos      = word_idx_reg * POS_BITS'(W) + POS_BITS'(j_reg);
    assign out_buf_done = out_valid & last_kmer &
                          (word_idx_reg == POS_BITS'(BLOCK_WORDS - 1));
    assign out_overflow = overflow_reg;

endmodule

// File: tb/tb_proj_fm_kmer_reader.sv
// Directed bench for the k-mer reader: a word-level scoreboard predicts every
// presented k-mer, and literal checks pin latency, overflow and reset behaviour.
module tb_proj_fm_kmer_reader;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_rdata;
    logic        in_rvalid;
    logic        in_buf_start;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_kmer;
    logic [8:0]  out_pos;
    logic        out_buf_done;
    logic        out_overflow;

    typedef struct {
        logic [31:0] kmer;
        logic [8:0]  pos;
        logic        done;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   last_done_pos = -1;
    int   m_widx = 0;
    bit   m_seen = 0;
    bit   m_ovf = 0;

    proj_fm_kmer_reader dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .in_rdata     (in_rdata),
        .in_rvalid    (in_rvalid),
        .in_buf_start (in_buf_start),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_kmer     (out_kmer),
        .out_pos      (out_pos),
        .out_buf_done (out_buf_done),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mkword(input int n);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'((n * 8 + b) & 255);
        return w;
    endfunction

    // Every accepted word contributes 5 overlapping 4-byte k-mers, in arrival order.
    task automatic model_accept(input logic [63:0] w, input bit st);
        exp_t e;
        if (st) m_widx = 0;
        else if (m_seen) m_widx = (m_widx + 1) % 64;
        m_seen = 1;
        for (int j = 0; j < 5; j++) begin
            e.kmer = 32'(w >> (8 * j));
            e.pos  = 9'((m_widx * 8 + j) % 512);
            e.done = (j == 4) && (m_widx == 63);
            q.push_back(e);
        end
    endtask

    task automatic push(input logic [63:0] w, input bit st, input bit drop);
        in_rvalid    = 1'b1;
        in_rdata     = w;
        in_buf_start = st;
        @(posedge clk);
        #1;
        if (drop) m_ovf = 1;
        else model_accept(w, st);
        in_rvalid    = 1'b0;
        in_buf_start = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0 && !out_valid) ok = 1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    // Compare process: checks the presented k-mer on every valid cycle, stalled or not.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("overflow_flag", 64'(out_overflow), 64'(m_ovf));
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_kmer: got kmer 0x%0h pos %0d, expected none", out_kmer, out_pos);
                end else begin
                    chk("kmer", 64'(out_kmer), 64'(q[0].kmer));
                    chk("pos", 64'(out_pos), 64'(q[0].pos));
                    chk("buf_done", 64'(out_buf_done), 64'(q[0].done));
                    if (in_ready) begin
                        void'(q.pop_front());
                        hs_cnt++;
                        if (out_buf_done) begin
                            done_cnt++;
                            last_done_pos = int'(out_pos);
                        end
                    end
                end
            end else begin
                chk("buf_done_idle", 64'(out_buf_done), 64'd0);
            end
        end
    end

    initial begin
        int  exp_pos[10] = '{0, 1, 2, 3, 4, 8, 9, 10, 11, 12};
        bit  [3:0] pat = 4'b1001;
        int  base;
        int  dbase;
        rst_n        = 1'b0;
        in_rdata     = '0;
        in_rvalid    = 1'b0;
        in_buf_start = 1'b0;
        in_ready     = 1'b1;

        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_kmer", 64'(out_kmer), 64'd0);
        chk("rst_pos", 64'(out_pos), 64'd0);
        chk("rst_done", 64'(out_buf_done), 64'd0);
        chk("rst_ovf", 64'(out_overflow), 64'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic + back-to-back: two words on consecutive cycles
        push(64'h0706050403020100, 1, 0);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        push(64'h0F0E0D0C0B0A0908, 0, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("nobubble_valid", 64'(out_valid), 64'd1);
            chk("lit_pos", 64'(out_pos), 64'(exp_pos[c]));
            if (c == 0) chk("lit_kmer0", 64'(out_kmer), 64'h03020100);
            if (c == 4) chk("lit_kmer4", 64'(out_kmer), 64'h07060504);
            if (c == 5) chk("lit_kmer5", 64'(out_kmer), 64'h0B0A0908);
        end
        @(negedge clk);
        chk("idle_after_b2b", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Backpressure: in_ready cycles 1,0,0,1
        base = hs_cnt;
        push(mkword(2), 0, 0);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            in_ready = pat[c % 4];
            if (q.size() == 0 && !out_valid) break;
        end
        in_ready = 1'b1;
        drain("bp_drain");
        chk("bp_kmer_count", 64'(hs_cnt - base), 64'd5);

        // Overflow: 5 words accepted with in_ready low, the 6th is dropped
        in_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mkword(20 + i), 0, 0);
        chk("ovf_clear_at_5", 64'(out_overflow), 64'd0);
        push(mkword(25), 0, 1);
        chk("ovf_set", 64'(out_overflow), 64'd1);
        base = hs_cnt;
        in_ready = 1'b1;
        drain("ovf_drain");
        chk("ovf_kmer_count", 64'(hs_cnt - base), 64'd25);

        // Buffer boundary: 64 words, done only at pos 508, then restart
        dbase = done_cnt;
        for (int n = 0; n < 64; n++) begin
            push(mkword(n), n == 0, 0);
            repeat (4) @(posedge clk);
            #1;
        end
        drain("blk_drain");
        chk("blk_done_count", 64'(done_cnt - dbase), 64'd1);
        chk("blk_done_pos", 64'(last_done_pos), 64'd508);
        push(mkword(7), 1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("restart_valid", 64'(out_valid), 64'd1);
        chk("restart_pos", 64'(out_pos), 64'd0);
        drain("restart_drain");

        // Reset mid-EMIT at j=2
        push(mkword(50), 1, 0);
        base = hs_cnt;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (hs_cnt - base >= 2) break;
        end
        chk("pre_rst_pos_j2", 64'(out_pos), 64'd2);
        chk("pre_rst_ovf", 64'(out_overflow), 64'd1);
        rst_n = 1'b0;
        q.delete();
        m_seen = 0;
        m_widx = 0;
        m_ovf  = 0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ovf", 64'(out_overflow), 64'd0);
        chk("midrst_pos", 64'(out_pos), 64'd0);
        chk("midrst_kmer", 64'(out_kmer), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(mkword(100), 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("postrst_valid", 64'(out_valid), 64'd1);
        chk("postrst_pos", 64'(out_pos), 64'd0);
        drain("postrst_drain");
        chk("leftover", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
